ds_interp_feeder: RTL and testbench

Sample-rate feeder for the first-order delta-sigma DAC stage. Accepts signed PCM samples over a valid/ready handshake and converts them to offset-binary. Linearly interpolates by 2^INTERP_LOG2 and emits one NB_BIT-wide unsigned word per trigger pulse. Its `data_o`/`trig_o` connect directly to the modulator's `data_i`/`trig_i`.

---
 rtl/ds_pkg.sv | 20 ++
 rtl/ds_trig_gen.sv | 33 +++
 rtl/ds_interp_feeder.sv | 170 +++++++++++++++++
 tb/tb_ds_interp_feeder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared definitions for the delta-sigma interpolating feeder: FSM encoding,
// midscale constant and the two's-complement to offset-binary conversion.
package ds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_e;

  function automatic logic [63:0] midscale(input int nb);
    return 64'(1) << (nb - 1);
  endfunction

  // Flipping the sign bit maps the signed range onto 0..2^w-1 monotonically
  function automatic logic [63:0] offset_bin(input logic [63:0] x, input int w);
    return x ^ (64'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/ds_trig_gen.sv
// Trigger divider: free-running down-counter producing a one-cycle tick every
// div_i+1 cycles while enabled; held at div_i while disabled.
module ds_trig_gen #(
  parameter int DIV_SIZE = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DIV_SIZE-1:0] div_i,
  output logic                tick_o
);

  logic [DIV_SIZE-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!en_i) begin
      cnt_d = div_i;
    end else if (cnt_q == '0) begin
      tick_o = 1'b1;
      cnt_d  = div_i;
    end else begin
      cnt_d = cnt_q - DIV_SIZE'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ds_interp_feeder.sv
// Sample-rate feeder for the delta-sigma DAC: accepts signed PCM, converts to
// offset-binary and linearly interpolates by 2^INTERP_LOG2, one word per trigger.
module ds_interp_feeder
  import ds_pkg::*;
#(
  parameter int DATA_SIZE   = 16,
  parameter int NB_BIT      = 32,
  parameter int INTERP_LOG2 = 2,
  parameter int DIV_SIZE    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [DIV_SIZE-1:0]  div_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 data_en_i,
  output logic                 data_rdy_o,
  output logic [NB_BIT-1:0]    data_o,
  output logic                 trig_o,
  output logic                 underflow_o,
  input  logic                 clr_underflow_i
);

  localparam int AW = DATA_SIZE + INTERP_LOG2;
  localparam int PW = (INTERP_LOG2 > 0) ? INTERP_LOG2 : 1;
  localparam int SH = NB_BIT - AW;
  localparam logic [PW-1:0]     PH_LAST = PW'((1 << INTERP_LOG2) - 1);
  localparam logic [NB_BIT-1:0] MID     = NB_BIT'(midscale(NB_BIT));

  state_e                      state_q, state_d;
  logic [DATA_SIZE-1:0]        nxt_q, nxt_d;
  logic                        nxt_v_q, nxt_v_d;
  logic [DATA_SIZE-1:0]        cur_q, cur_d;
  logic signed [DATA_SIZE:0]   stp_q, stp_d;
  logic [AW-1:0]               acc_q, acc_d;
  logic [PW-1:0]               ph_q, ph_d;
  logic [NB_BIT-1:0]           data_q, data_d;
  logic                        trig_q, trig_d;
  logic                        uf_q, uf_d;

  logic                        run_en;
  logic                        tick;
  logic                        accept;
  logic                        load_out;
  logic                        uf_set;
  logic [DATA_SIZE-1:0]        u;

  assign run_en     = enable_i && (state_q != ST_IDLE);
  assign data_rdy_o = run_en && !nxt_v_q;
  assign accept     = data_en_i && data_rdy_o;
  assign u          = DATA_SIZE'(offset_bin(64'(data_i), DATA_SIZE));

  ds_trig_gen #(
    .DIV_SIZE(DIV_SIZE)
  ) u_trig_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (run_en),
    .div_i (div_i),
    .tick_o(tick)
  );

  // Segment sequencing: the step is added 2^L-1 times, then the accumulator is
  // re-anchored to the exact target so rounding never drifts across segments.
  always_comb begin
    state_d  = state_q;
    nxt_d    = nxt_q;
    nxt_v_d  = nxt_v_q;
    cur_d    = cur_q;
    stp_d    = stp_q;
    acc_d    = acc_q;
    ph_d     = ph_q;
    data_d   = data_q;
    trig_d   = 1'b0;
    load_out = 1'b0;
    uf_set   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        nxt_v_d = 1'b0;
        ph_d    = '0;
        if (enable_i) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (tick) begin
          trig_d = 1'b1;
          if (nxt_v_q) begin
            cur_d    = nxt_q;
            acc_d    = AW'(nxt_q) << INTERP_LOG2;
            stp_d    = '0;
            nxt_v_d  = 1'b0;
            ph_d     = '0;
            load_out = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (tick) begin
          trig_d   = 1'b1;
          load_out = 1'b1;
          if (ph_q != PH_LAST) begin
            acc_d = acc_q + AW'(stp_q);
            ph_d  = ph_q + PW'(1);
          end else begin
            acc_d = AW'(cur_q) << INTERP_LOG2;
            ph_d  = '0;
            if (nxt_v_q) begin
              stp_d   = $signed({1'b0, nxt_q}) - $signed({1'b0, cur_q});
              cur_d   = nxt_q;
              nxt_v_d = 1'b0;
            end else begin
              stp_d  = '0;
              uf_set = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_out) data_d = NB_BIT'(acc_d) << SH;

    if (accept) begin
      nxt_d   = u;
      nxt_v_d = 1'b1;
    end

    // Disabling overrides everything and discards the pending sample
    if (!enable_i) begin
      state_d = ST_IDLE;
      nxt_v_d = 1'b0;
    end

    if (uf_set)               uf_d = 1'b1;
    else if (clr_underflow_i) uf_d = 1'b0;
    else                      uf_d = uf_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      nxt_q   <= '0;
      nxt_v_q <= 1'b0;
      cur_q   <= '0;
      stp_q   <= '0;
      acc_q   <= '0;
      ph_q    <= '0;
      data_q  <= MID;
      trig_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      nxt_v_q <= nxt_v_d;
      cur_q   <= cur_d;
      stp_q   <= stp_d;
      acc_q   <= acc_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
      trig_q  <= trig_d;
      uf_q    <= uf_d;
    end
  end

  assign data_o      = data_q;
  assign trig_o      = trig_q;
  assign underflow_o = uf_q;

endmodule

// File: tb/tb_ds_interp_feeder.sv
// Self-checking bench for ds_interp_feeder: a segment-level reference model
// checked every cycle, plus literal output sequences for the directed cases.
module tb_ds_interp_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_i = 1'b0;
  logic [15:0] div_i = 16'd3;
  logic [15:0] data_i = '0;
  logic        data_en_i = 1'b0;
  logic        clr_underflow_i = 1'b0;
  logic        data_rdy_o;
  logic [31:0] data_o;
  logic        trig_o;
  logic        underflow_o;

  int testsRun = 0;
  int testsFailed = 0;

  ds_interp_feeder #(
    .DATA_SIZE(16), .NB_BIT(32), .INTERP_LOG2(2), .DIV_SIZE(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_i), .div_i(div_i),
    .data_i(data_i), .data_en_i(data_en_i), .data_rdy_o(data_rdy_o),
    .data_o(data_o), .trig_o(trig_o), .underflow_o(underflow_o),
    .clr_underflow_i(clr_underflow_i)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted offset-binary samples, a period counter
  // since enable, and the interpolation written as from*4 + j*(to-from).
  int unsigned  mQ[$];
  bit           mIdle = 1'b1;
  int           mCount = 0;
  bit           mStarted = 1'b0;
  longint       mFrom = 0;
  longint       mTo = 0;
  int           mJ = 0;
  logic [31:0]  mData = 32'h8000_0000;
  bit           mTrig = 1'b0;
  bit           mUf = 1'b0;
  int           mAccCount = 0;
  bit           checkEn = 1'b0;
  bit           recordOn = 1'b0;
  logic [31:0]  recQ[$];
  logic [31:0]  mRecQ[$];

  function automatic logic [31:0] accToOut(input longint a);
    return 32'(a << 14);
  endfunction

  task automatic modelTick(output bit uf);
    uf = 1'b0;
    if (!mStarted) begin
      if (mQ.size() > 0) begin
        mFrom = mQ.pop_front();
        mTo = mFrom;
        mJ = 0;
        mStarted = 1'b1;
        mData = accToOut(mFrom * 4);
      end
    end else begin
      mJ++;
      if (mJ == 4) begin
        mJ = 0;
        mFrom = mTo;
        if (mQ.size() > 0) mTo = mQ.pop_front();
        else uf = 1'b1;
      end
      mData = accToOut(mFrom * 4 + mJ * (mTo - mFrom));
    end
  endtask

  always @(posedge clk or posedge rst) begin : modelProc
    bit acceptNow;
    bit setNow;
    if (rst) begin
      mQ.delete();
      mIdle = 1'b1; mCount = 0; mStarted = 1'b0; mJ = 0;
      mData = 32'h8000_0000; mTrig = 1'b0; mUf = 1'b0;
    end else begin
      acceptNow = data_en_i && enable_i && !mIdle && (mQ.size() == 0);
      setNow = 1'b0;
      mTrig = 1'b0;
      if (!enable_i) begin
        mIdle = 1'b1;
        mQ.delete();
        mStarted = 1'b0;
      end else if (mIdle) begin
        mIdle = 1'b0;
        mCount = 0;
      end else begin
        mCount++;
        if (mCount % (int'(div_i) + 1) == 0) begin
          mTrig = 1'b1;
          modelTick(setNow);
        end
      end
      if (setNow) mUf = 1'b1;
      else if (clr_underflow_i) mUf = 1'b0;
      if (acceptNow) begin
        mQ.push_back({16'h0, data_i ^ 16'h8000});
        mAccCount++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && checkEn) begin
      checkOutput("trig", {31'b0, trig_o}, {31'b0, mTrig});
      checkOutput("data", data_o, mData);
      checkOutput("underflow", {31'b0, underflow_o}, {31'b0, mUf});
      checkOutput("rdy", {31'b0, data_rdy_o},
                  {31'b0, enable_i && !mIdle && (mQ.size() == 0)});
      if (recordOn && trig_o) recQ.push_back(data_o);
      if (recordOn && mTrig) mRecQ.push_back(mData);
    end
  end

  task automatic applyStimulus(input bit en, input logic [15:0] div);
    @(posedge clk); #1;
    enable_i = en;
    div_i = div;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushSample(input logic [15:0] v);
    int start;
    start = mAccCount;
    data_i = v;
    data_en_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (mAccCount != start) break;
    end
    data_en_i = 1'b0;
    checkOutput("pushAccepted", {31'b0, mAccCount != start}, 32'd1);
  endtask

  task automatic waitTrigs(input int n);
    for (int i = 0; i < 400; i++) begin
      if (recQ.size() >= n) break;
      @(negedge clk); #1;
    end
    checkOutput("trigsSeen", {31'b0, recQ.size() >= n}, 32'd1);
  endtask

  task automatic checkRec(input string name, input int idx, input logic [31:0] expected);
    checkOutput({name, "Dut"}, (idx < recQ.size()) ? recQ[idx] : 32'hXXXX_XXXX, expected);
    checkOutput({name, "Model"}, (idx < mRecQ.size()) ? mRecQ[idx] : 32'hXXXX_XXXX, expected);
  endtask

  task automatic restartRecording();
    applyStimulus(1'b0, div_i);
    waitCycles(1);
    clr_underflow_i = 1'b1;
    waitCycles(1);
    clr_underflow_i = 1'b0;
    recQ.delete();
    mRecQ.delete();
    recordOn = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] seqA [9];
    logic [31:0] seqB [9];
    int trigCnt;
    int accCnt;

    seqA = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
             32'h8040_0000, 32'h8080_0000, 32'h80C0_0000, 32'h8100_0000};
    seqB = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
             32'hBFFF_4000, 32'h7FFF_8000, 32'h3FFF_C000, 32'h0000_0000};

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rstData", data_o, 32'h8000_0000);
    checkOutput("rstTrig", {31'b0, trig_o}, 32'd0);
    checkOutput("rstRdy", {31'b0, data_rdy_o}, 32'd0);
    checkOutput("rstUnderflow", {31'b0, underflow_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    checkEn = 1'b1;

    $display("[TB] enable with no samples");
    applyStimulus(1'b1, 16'd3);
    waitCycles(10);
    checkOutput("idleRunRdy", {31'b0, data_rdy_o}, 32'd1);
    checkOutput("idleRunData", data_o, 32'h8000_0000);

    $display("[TB] ramp 0x0000 -> 0x0100");
    restartRecording();
    applyStimulus(1'b1, 16'd3);
    pushSample(16'h0000);
    pushSample(16'h0100);
    waitTrigs(9);
    for (int i = 0; i < 9; i++) checkRec("rampUp", i, seqA[i]);
    recordOn = 1'b0;

    $display("[TB] full-scale ramp 0x7FFF -> 0x8000 then underflow");
    restartRecording();
    applyStimulus(1'b1, 16'd3);
    pushSample(16'h7FFF);
    pushSample(16'h8000);
    waitTrigs(9);
    for (int i = 0; i < 9; i++) checkRec("rampDown", i, seqB[i]);
    checkOutput("underflowSet", {31'b0, underflow_o}, 32'd1);
    waitTrigs(13);
    for (int i = 9; i < 13; i++) checkRec("holdAfterUf", i, 32'h0000_0000);
    checkOutput("underflowSticky", {31'b0, underflow_o}, 32'd1);
    waitCycles(1);
    clr_underflow_i = 1'b1;
    waitCycles(1);
    clr_underflow_i = 1'b0;
    checkOutput("underflowCleared", {31'b0, underflow_o}, 32'd0);
    pushSample(16'h4000);
    waitTrigs(21);
    checkRec("resume0", 16, 32'h0000_0000);
    checkRec("resume1", 17, 32'h3000_0000);
    checkRec("resume2", 18, 32'h6000_0000);
    checkRec("resume3", 19, 32'h9000_0000);
    checkRec("resume4", 20, 32'hC000_0000);
    waitTrigs(24);
    clr_underflow_i = 1'b1;
    waitTrigs(25);
    checkOutput("setWinsOverClear", {31'b0, underflow_o}, 32'd1);
    waitCycles(1);
    clr_underflow_i = 1'b0;
    recordOn = 1'b0;

    $display("[TB] div=0 continuous stream");
    applyStimulus(1'b0, 16'd0);
    waitCycles(1);
    clr_underflow_i = 1'b1;
    waitCycles(1);
    clr_underflow_i = 1'b0;
    applyStimulus(1'b1, 16'd0);
    data_en_i = 1'b1;
    data_i = 16'h1234;
    trigCnt = 0;
    accCnt = 0;
    begin
      int lastAcc;
      int k;
      lastAcc = mAccCount;
      k = 1;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (i >= 20) begin
          if (trig_o) trigCnt++;
          if (data_en_i && data_rdy_o) accCnt++;
        end
        @(posedge clk); #1;
        if (mAccCount != lastAcc) begin
          lastAcc = mAccCount;
          k++;
          data_i = 16'(k * 16'h1357);
        end
      end
    end
    data_en_i = 1'b0;
    checkOutput("streamTrigs", trigCnt, 32'd40);
    checkOutput("streamAccepts", accCnt, 32'd10);
    checkOutput("streamNoUnderflow", {31'b0, underflow_o}, 32'd0);

    $display("[TB] disable mid-segment and re-enable");
    applyStimulus(1'b0, 16'd3);
    waitCycles(1);
    clr_underflow_i = 1'b1;
    waitCycles(1);
    clr_underflow_i = 1'b0;
    applyStimulus(1'b1, 16'd3);
    pushSample(16'h1000);
    pushSample(16'h2000);
    waitCycles(9);
    applyStimulus(1'b0, 16'd3);
    trigCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (trig_o) trigCnt++;
      checkOutput("disabledRdy", {31'b0, data_rdy_o}, 32'd0);
    end
    checkOutput("disabledTrigs", trigCnt, 32'd0);
    applyStimulus(1'b1, 16'd3);
    waitCycles(12);
    pushSample(16'h3000);
    waitCycles(20);

    $display("[TB] asynchronous reset mid-run");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstData", data_o, 32'h8000_0000);
    checkOutput("asyncRstTrig", {31'b0, trig_o}, 32'd0);
    waitCycles(2);
    rst = 1'b0;
    waitCycles(8);
    pushSample(16'hF000);
    waitCycles(24);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
